// File: rtl/ndigit_display_pkg.sv
// ---------------------------------------------------------------------------
// ndigit_display_pkg
// Shared definitions for the N-digit seven-segment driver:
//   SEG_TABLE  - active-low {g,f,e,d,c,b,a} patterns for hex values 0..F
//   SEG_OFF    - all segments dark
//   an_off()   - anode mask with the low n bits set (all digits dark)
//   frame_t    - one display frame (digits, dots, blank, flash), sized for
//                the largest supported digit count; unused bits stay zero
// ---------------------------------------------------------------------------
package ndigit_display_pkg;

    localparam int MAX_DIGITS = 8;
    localparam int MAX_IDX_W  = $clog2(MAX_DIGITS);

    localparam logic [6:0] SEG_OFF = 7'h7F;

    // Entry [15] is listed first so that SEG_TABLE[v] decodes value v.
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

    function automatic logic [MAX_DIGITS-1:0] an_off(input int n);
        logic [MAX_DIGITS-1:0] m;
        m = '0;
        for (int i = 0; i < MAX_DIGITS; i++) begin
            if (i < n) m[i] = 1'b1;
        end
        return m;
    endfunction

    typedef struct packed {
        logic [4*MAX_DIGITS-1:0] digits;
        logic [MAX_DIGITS-1:0]   dots;
        logic [MAX_DIGITS-1:0]   blank;
        logic [MAX_DIGITS-1:0]   flash;
    } frame_t;

endpackage

// File: rtl/seg_hex_decoder.sv
// ---------------------------------------------------------------------------
// seg_hex_decoder
// Combinational hex-to-seven-segment decoder, active-low outputs.
//   value : in  4-bit hex value
//   seg   : out {g,f,e,d,c,b,a}, 0 = segment lit
// ---------------------------------------------------------------------------
module seg_hex_decoder
    import ndigit_display_pkg::*;
(
    input  logic [3:0] value,
    output logic [6:0] seg
);

    assign seg = SEG_TABLE[value];

endmodule

// File: rtl/ndigit_display_driver.sv
// ---------------------------------------------------------------------------
// ndigit_display_driver
// Time-multiplexed driver for NUM_DIGITS common-anode seven-segment digits
// with per-digit blank/flash, PWM brightness and a double-buffered frame.
//   clk, rst_n      : clock, synchronous active-low reset
//   load_valid/ready: frame handshake; a frame is held pending until the
//                     next frame boundary and then becomes the active frame
//   digits_in       : nibble i = digit i (digit 0 rightmost)
//   dots_in         : decimal points, 1 = lit
//   blank_in        : 1 = digit dark
//   flash_in        : 1 = digit dark during the odd flash phase
//   brightness      : live PWM duty, 0 = dark
//   an, seg, dp     : registered active-low pin drives
//   frame_sync      : one-cycle pulse when digit 0's slot begins
// Build option: LEADING_ZERO_BLANK_EN auto-blanks leading zero digits at
// commit time (digit 0 is always kept).
// ---------------------------------------------------------------------------
module ndigit_display_driver
    import ndigit_display_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_BITS = 18,
    parameter int FLASH_BITS   = 26,
    parameter int BRIGHT_BITS  = 3
)(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load_valid,
    output logic                    load_ready,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic [NUM_DIGITS-1:0]   dots_in,
    input  logic [NUM_DIGITS-1:0]   blank_in,
    input  logic [NUM_DIGITS-1:0]   flash_in,
    input  logic [BRIGHT_BITS-1:0]  brightness,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic                    frame_sync
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [IDX_W-1:0]      LAST_IDX   = IDX_W'(NUM_DIGITS - 1);
    localparam logic [MAX_DIGITS-1:0] AN_OFF_ALL = an_off(NUM_DIGITS);
    localparam logic [NUM_DIGITS-1:0] AN_OFF     = AN_OFF_ALL[NUM_DIGITS-1:0];
    localparam frame_t RESET_FRAME = '{digits: '0, dots: '0, blank: AN_OFF_ALL, flash: '0};

    logic [REFRESH_BITS-1:0] rcnt;
    logic [FLASH_BITS-1:0]   fcnt;
    logic                    started;
    logic                    fphase;
    logic                    fphase_nxt;
    logic [IDX_W-1:0]        idx;
    logic [IDX_W-1:0]        sel;
    logic [MAX_IDX_W-1:0]    sel_w;
    logic                    tick;
    logic                    frame_start;
    logic                    commit;
    logic                    capture;
    logic                    pend_full;
    frame_t                  act;
    frame_t                  pend;
    frame_t                  frame_in;
    frame_t                  commit_frame;
    frame_t                  shown;
    logic [BRIGHT_BITS-1:0]  pwm;
    logic                    dark;
    logic [3:0]              digit_val;
    logic [6:0]              dec_seg;

    assign tick        = (rcnt == '0);
    // started is low only in the first cycle after reset, which keeps that
    // cycle's counter==0 from counting as a flash wrap or a slot advance.
    assign fphase_nxt  = fphase ^ (started && (fcnt == '0));
    assign frame_start = tick && (sel == '0);
    assign commit      = frame_start && pend_full;
    assign capture     = load_valid && !pend_full;
    assign load_ready  = !pend_full;

    always_comb begin
        sel = idx;
        if (tick) begin
            if (!started || idx == LAST_IDX) sel = '0;
            else                             sel = idx + IDX_W'(1);
        end
    end

    assign sel_w = MAX_IDX_W'(sel);

    always_comb begin
        frame_in = '0;
        frame_in.digits[4*NUM_DIGITS-1:0] = digits_in;
        frame_in.dots[NUM_DIGITS-1:0]     = dots_in;
        frame_in.blank[NUM_DIGITS-1:0]    = blank_in;
        frame_in.flash[NUM_DIGITS-1:0]    = flash_in;
    end

`ifdef LEADING_ZERO_BLANK_EN
    logic [MAX_DIGITS-1:0] lz_blank;
    logic                  zero_run;

    // Walk from the top digit down; a digit is blanked while it and every
    // digit above it are zero. Digit 0 is excluded so "0" still shows.
    always_comb begin
        lz_blank = '0;
        zero_run = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            zero_run    = zero_run && (pend.digits[4*i +: 4] == 4'h0);
            lz_blank[i] = zero_run;
        end
        commit_frame       = pend;
        commit_frame.blank = pend.blank | lz_blank;
    end
`else
    assign commit_frame = pend;
`endif

    // Outputs are registered from the slot being entered, so on a commit
    // tick the incoming frame is what gets displayed.
    assign shown     = commit ? commit_frame : act;
    assign digit_val = shown.digits[{sel_w, 2'b00} +: 4];
    assign pwm       = rcnt[REFRESH_BITS-1 -: BRIGHT_BITS];
    assign dark      = shown.blank[sel_w]
                    || (shown.flash[sel_w] && fphase_nxt)
                    || (pwm >= brightness);

    seg_hex_decoder u_dec (
        .value (digit_val),
        .seg   (dec_seg)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rcnt       <= '0;
            fcnt       <= '0;
            started    <= 1'b0;
            fphase     <= 1'b0;
            idx        <= '0;
            pend_full  <= 1'b0;
            pend       <= '0;
            act        <= RESET_FRAME;
            an         <= AN_OFF;
            seg        <= SEG_OFF;
            dp         <= 1'b1;
            frame_sync <= 1'b0;
        end else begin
            rcnt       <= rcnt + REFRESH_BITS'(1);
            fcnt       <= fcnt + FLASH_BITS'(1);
            started    <= 1'b1;
            fphase     <= fphase_nxt;
            idx        <= sel;
            frame_sync <= frame_start;

            // Capture needs an empty buffer and commit a full one, so the
            // two never coincide.
            if (capture) begin
                pend      <= frame_in;
                pend_full <= 1'b1;
            end else if (commit) begin
                pend_full <= 1'b0;
            end
            if (commit) act <= commit_frame;

            if (dark) begin
                an  <= AN_OFF;
                seg <= SEG_OFF;
                dp  <= 1'b1;
            end else begin
                an  <= ~(NUM_DIGITS'(1) << sel);
                seg <= dec_seg;
                dp  <= ~shown.dots[sel_w];
            end
        end
    end

endmodule

// File: tb/tb_ndigit_display_driver.sv
module tb_ndigit_display_driver;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load_valid = 1'b0;
    logic        load_ready;
    logic [15:0] digits_in = '0;
    logic [3:0]  dots_in = '0;
    logic [3:0]  blank_in = '0;
    logic [3:0]  flash_in = '0;
    logic [1:0]  brightness = 2'd3;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_sync;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ndigit_display_driver #(
        .NUM_DIGITS   (4),
        .REFRESH_BITS (4),
        .FLASH_BITS   (7),
        .BRIGHT_BITS  (2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .digits_in  (digits_in),
        .dots_in    (dots_in),
        .blank_in   (blank_in),
        .flash_in   (flash_in),
        .brightness (brightness),
        .an         (an),
        .seg        (seg),
        .dp         (dp),
        .frame_sync (frame_sync)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Advances at least one negedge, then waits (bounded) for frame_sync.
    task automatic wait_fsync(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (frame_sync) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Offers a frame and holds load_valid until it is taken; returns at the
    // negedge after the capturing edge with load_valid dropped.
    task automatic do_load(input logic [15:0] d, input logic [3:0] dt,
                           input logic [3:0] bl, input logic [3:0] fl,
                           output bit ok);
        ok = 1'b0;
        digits_in  = d;
        dots_in    = dt;
        blank_in   = bl;
        flash_in   = fl;
        load_valid = 1'b1;
        for (int i = 0; i < 300; i++) begin
            if (load_ready) begin
                @(posedge clk);
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        load_valid = 1'b0;
    endtask

    task automatic test_reset();
        int dark_bad, ready_bad, fs_cnt, fs_first, fs_last, fs_gap_bad;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        total++; if (an !== 4'hF) begin bad++; $display("FAIL reset_an got=%h exp=f", an); end
        total++; if (seg !== 7'h7F) begin bad++; $display("FAIL reset_seg got=%h exp=7f", seg); end
        total++; if (dp !== 1'b1) begin bad++; $display("FAIL reset_dp got=%b exp=1", dp); end
        total++; if (frame_sync !== 1'b0) begin bad++; $display("FAIL reset_fsync got=%b exp=0", frame_sync); end
        total++; if (load_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", load_ready); end
        rst_n = 1'b1;
        dark_bad = 0; ready_bad = 0; fs_cnt = 0; fs_first = -1; fs_last = -1; fs_gap_bad = 0;
        for (int s = 0; s < 200; s++) begin
            @(negedge clk);
            if (an !== 4'hF || seg !== 7'h7F || dp !== 1'b1) dark_bad++;
            if (load_ready !== 1'b1) ready_bad++;
            if (frame_sync === 1'b1) begin
                if (fs_first < 0) fs_first = s;
                else if (s - fs_last != 64) fs_gap_bad++;
                fs_last = s;
                fs_cnt++;
            end
        end
        total++; if (dark_bad != 0) begin bad++; $display("FAIL idle_dark lit_cycles=%0d exp=0", dark_bad); end
        total++; if (ready_bad != 0) begin bad++; $display("FAIL idle_ready low_cycles=%0d exp=0", ready_bad); end
        total++; if (fs_cnt != 4) begin bad++; $display("FAIL idle_fsync_count got=%0d exp=4", fs_cnt); end
        total++; if (fs_first != 0) begin bad++; $display("FAIL idle_fsync_first got=%0d exp=0", fs_first); end
        total++; if (fs_gap_bad != 0) begin bad++; $display("FAIL idle_fsync_period bad_gaps=%0d exp=0", fs_gap_bad); end
    endtask

    task automatic test_reset_mid_load();
        bit ok;
        int lit;
        do_load(16'h1234, 4'b0000, 4'b0000, 4'b0000, ok);
        total++; if (!ok) begin bad++; $display("FAIL midload_capture got=timeout exp=taken"); end
        total++; if (load_ready !== 1'b0) begin bad++; $display("FAIL midload_pending got=%b exp=0", load_ready); end
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        lit = 0;
        for (int s = 0; s < 130; s++) begin
            @(negedge clk);
            if (an !== 4'hF) lit++;
        end
        total++; if (lit != 0) begin bad++; $display("FAIL midload_discard lit_cycles=%0d exp=0", lit); end
        total++; if (load_ready !== 1'b1) begin bad++; $display("FAIL midload_ready got=%b exp=1", load_ready); end
    endtask

    task automatic test_load();
        bit ok;
        do_load(16'h1234, 4'b0010, 4'b0000, 4'b0000, ok);
        total++; if (!ok) begin bad++; $display("FAIL load_capture got=timeout exp=taken"); end
        total++; if (load_ready !== 1'b0) begin bad++; $display("FAIL load_ready_drop got=%b exp=0", load_ready); end
        wait_fsync(ok);
        total++; if (!ok) begin bad++; $display("FAIL load_fsync got=timeout exp=pulse"); end
        total++; if (load_ready !== 1'b1) begin bad++; $display("FAIL load_ready_rise got=%b exp=1", load_ready); end
        for (int s = 0; s < 64; s++) begin
            if (s > 0) @(negedge clk);
            case (s)
                0: begin
                    total++; if (an !== 4'b1110) begin bad++; $display("FAIL load_s0_an got=%b exp=1110", an); end
                    total++; if (seg !== 7'h19) begin bad++; $display("FAIL load_s0_seg got=%h exp=19", seg); end
                    total++; if (dp !== 1'b1) begin bad++; $display("FAIL load_s0_dp got=%b exp=1", dp); end
                end
                12: begin
                    total++; if (an !== 4'hF) begin bad++; $display("FAIL load_pwm_off got=%b exp=1111", an); end
                end
                16: begin
                    total++; if (an !== 4'b1101) begin bad++; $display("FAIL load_s1_an got=%b exp=1101", an); end
                    total++; if (seg !== 7'h30) begin bad++; $display("FAIL load_s1_seg got=%h exp=30", seg); end
                    total++; if (dp !== 1'b0) begin bad++; $display("FAIL load_s1_dp got=%b exp=0", dp); end
                end
                32: begin
                    total++; if (an !== 4'b1011 || seg !== 7'h24) begin bad++; $display("FAIL load_s2 got an=%b seg=%h exp an=1011 seg=24", an, seg); end
                end
                48: begin
                    total++; if (an !== 4'b0111 || seg !== 7'h79) begin bad++; $display("FAIL load_s3 got an=%b seg=%h exp an=0111 seg=79", an, seg); end
                end
                default: ;
            endcase
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        logic [6:0] exp_a [4];
        logic [6:0] exp_b [4];
        logic [6:0] exp_seg;
        int slot;
        exp_a = '{7'h19, 7'h30, 7'h24, 7'h79};
        exp_b = '{7'h00, 7'h78, 7'h02, 7'h12};
        do_load(16'h1234, 4'b0000, 4'b0000, 4'b0000, ok);
        total++; if (!ok) begin bad++; $display("FAIL b2b_capture_a got=timeout exp=taken"); end
        digits_in  = 16'h5678;
        load_valid = 1'b1;
        total++; if (load_ready !== 1'b0) begin bad++; $display("FAIL b2b_busy got=%b exp=0", load_ready); end
        wait_fsync(ok);
        total++; if (!ok) begin bad++; $display("FAIL b2b_fsync got=timeout exp=pulse"); end
        total++; if (load_ready !== 1'b1) begin bad++; $display("FAIL b2b_b_held got=%b exp=1", load_ready); end
        for (int s = 0; s < 128; s++) begin
            if (s > 0) @(negedge clk);
            if (s == 1) begin
                total++; if (load_ready !== 1'b0) begin bad++; $display("FAIL b2b_capture_b got=%b exp=0", load_ready); end
                load_valid = 1'b0;
            end
            if (s == 64) begin
                total++; if (frame_sync !== 1'b1) begin bad++; $display("FAIL b2b_fsync2 got=%b exp=1", frame_sync); end
            end
            if (s % 16 == 0) begin
                slot = (s / 16) % 4;
                exp_seg = (s < 64) ? exp_a[slot] : exp_b[slot];
                total++;
                if (seg !== exp_seg) begin
                    bad++;
                    $display("FAIL b2b_seg s=%0d got=%h exp=%h", s, seg, exp_seg);
                end
            end
        end
    endtask

    task automatic test_flash();
        bit ok;
        int f;
        logic [3:0] exp_an;
        rst_n      = 1'b0;
        digits_in  = 16'h1234;
        dots_in    = 4'b0000;
        blank_in   = 4'b0000;
        flash_in   = 4'b0001;
        brightness = 2'd3;
        load_valid = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        total++; if (load_ready !== 1'b0) begin bad++; $display("FAIL flash_capture got=%b exp=0", load_ready); end
        load_valid = 1'b0;
        wait_fsync(ok);
        total++; if (!ok) begin bad++; $display("FAIL flash_fsync got=timeout exp=pulse"); end
        for (int s = 0; s < 256; s++) begin
            if (s > 0) @(negedge clk);
            f = s / 64;
            if (s % 64 == 0) begin
                exp_an = (f == 0 || f == 3) ? 4'b1110 : 4'b1111;
                total++;
                if (an !== exp_an) begin
                    bad++;
                    $display("FAIL flash_d0 frame=%0d got=%b exp=%b", f, an, exp_an);
                end
            end
            if (s % 64 == 16) begin
                total++;
                if (an !== 4'b1101) begin
                    bad++;
                    $display("FAIL flash_d1 frame=%0d got=%b exp=1101", f, an);
                end
            end
        end
        flash_in = 4'b0000;
    endtask

    task automatic test_brightness();
        bit ok;
        int lit [4];
        int any_lit;
        int slot;
        logic [3:0] exp_an;
        do_load(16'h1234, 4'b0000, 4'b0000, 4'b0000, ok);
        total++; if (!ok) begin bad++; $display("FAIL bright_capture got=timeout exp=taken"); end
        brightness = 2'd1;
        wait_fsync(ok);
        total++; if (!ok) begin bad++; $display("FAIL bright_fsync got=timeout exp=pulse"); end
        lit = '{0, 0, 0, 0};
        for (int s = 0; s < 64; s++) begin
            if (s > 0) @(negedge clk);
            slot = s / 16;
            exp_an = ~(4'b0001 << slot);
            if (an === exp_an) lit[slot]++;
        end
        for (int d = 0; d < 4; d++) begin
            total++;
            if (lit[d] != 4) begin
                bad++;
                $display("FAIL bright1_duty slot=%0d got=%0d exp=4", d, lit[d]);
            end
        end
        brightness = 2'd0;
        wait_fsync(ok);
        total++; if (!ok) begin bad++; $display("FAIL bright0_fsync got=timeout exp=pulse"); end
        any_lit = 0;
        for (int s = 0; s < 64; s++) begin
            if (s > 0) @(negedge clk);
            if (an !== 4'hF) any_lit++;
        end
        total++; if (any_lit != 0) begin bad++; $display("FAIL bright0_dark lit_cycles=%0d exp=0", any_lit); end
        brightness = 2'd3;
    endtask

    task automatic test_leading_zero();
        bit ok;
        logic [3:0] exp_an [4];
        logic [6:0] exp_seg [4];
        logic [3:0] exp_an0 [4];
        int slot;
`ifdef LEADING_ZERO_BLANK_EN
        exp_an  = '{4'b1110, 4'b1101, 4'b1111, 4'b1111};
        exp_seg = '{7'h40, 7'h78, 7'h7F, 7'h7F};
        exp_an0 = '{4'b1110, 4'b1111, 4'b1111, 4'b1111};
`else
        exp_an  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        exp_seg = '{7'h40, 7'h78, 7'h40, 7'h40};
        exp_an0 = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
`endif
        do_load(16'h0070, 4'b1100, 4'b0000, 4'b0000, ok);
        total++; if (!ok) begin bad++; $display("FAIL lzb_capture got=timeout exp=taken"); end
        wait_fsync(ok);
        total++; if (!ok) begin bad++; $display("FAIL lzb_fsync got=timeout exp=pulse"); end
        for (int s = 0; s < 64; s++) begin
            if (s > 0) @(negedge clk);
            if (s % 16 == 0) begin
                slot = s / 16;
                total++;
                if (an !== exp_an[slot] || seg !== exp_seg[slot]) begin
                    bad++;
                    $display("FAIL lzb_0070 slot=%0d got an=%b seg=%h exp an=%b seg=%h",
                             slot, an, seg, exp_an[slot], exp_seg[slot]);
                end
`ifdef LEADING_ZERO_BLANK_EN
                if (slot >= 2) begin
                    total++;
                    if (dp !== 1'b1) begin bad++; $display("FAIL lzb_dot slot=%0d got=%b exp=1", slot, dp); end
                end
`endif
            end
        end
        do_load(16'h0000, 4'b0000, 4'b0000, 4'b0000, ok);
        total++; if (!ok) begin bad++; $display("FAIL lzb0_capture got=timeout exp=taken"); end
        wait_fsync(ok);
        total++; if (!ok) begin bad++; $display("FAIL lzb0_fsync got=timeout exp=pulse"); end
        for (int s = 0; s < 64; s++) begin
            if (s > 0) @(negedge clk);
            if (s % 16 == 0) begin
                slot = s / 16;
                total++;
                if (an !== exp_an0[slot]) begin
                    bad++;
                    $display("FAIL lzb_0000 slot=%0d got an=%b exp an=%b", slot, an, exp_an0[slot]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_reset_mid_load();
        test_load();
        test_back_to_back();
        test_flash();
        test_brightness();
        test_leading_zero();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
